// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one-hot column drive, 2-flop row synchronizer,
// press/release debounce and a one-cycle valid pulse carrying the hex code of each new key.
module keypad_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES   = 48,
    parameter int unsigned DEBOUNCE_CYCLES = 480000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_keys,
    output logic [3:0] col_keys,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned MaxCycles =
        (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] DebLast    = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

    state_e          state_q, state_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;
    logic [3:0]      row_meta_q, row_s_q;
    logic [1:0]      low_row;
    logic            row_hit;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        unique case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'b0;
            row_s_q    <= 4'b0;
        end else begin
            row_meta_q <= row_keys;
            row_s_q    <= row_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StScan;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    // Lowest active row wins when several keys share the driven column.
    always_comb begin
        low_row = 2'd0;
        if (row_s_q[0])      low_row = 2'd0;
        else if (row_s_q[1]) low_row = 2'd1;
        else if (row_s_q[2]) low_row = 2'd2;
        else if (row_s_q[3]) low_row = 2'd3;
    end

    assign row_hit = row_s_q[row_idx_q];

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q + CntW'(1);
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        unique case (state_q)
            StScan: begin
                if (cnt_q == SettleLast) begin
                    cnt_d = '0;
                    if (row_s_q == 4'b0) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = low_row;
                        state_d   = StDebounce;
                    end
                end
            end
            StDebounce: begin
                if (!row_hit) begin
                    state_d = StScan;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d     = StHeld;
                    cnt_d       = '0;
                    key_code_d  = key_map(row_idx_q, col_idx_q);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end
            end
            StHeld: begin
                cnt_d = '0;
                if (!row_hit) state_d = StRelease;
            end
            StRelease: begin
                if (row_hit) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d    = StScan;
                    cnt_d      = '0;
                    key_held_d = 1'b0;
                    col_idx_d  = col_idx_q + 2'd1;
                end
            end
            default: begin
                state_d = StScan;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        col_keys  = 4'b0001 << col_idx_q;
        key_code  = key_code_q;
        key_valid = key_valid_q;
        key_held  = key_held_q;
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a keypad matrix model and a pulse scoreboard.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_keys;
    logic [3:0] col_keys;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] pressed [4];
    logic [3:0] exp_q [$];
    logic [3:0] mon_exp;
    logic [3:0] exp_col;
    bit         mon_en = 1'b0;
    int         checks = 0;
    int         fails  = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SETTLE_CYCLES  (3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_keys (row_keys),
        .col_keys (col_keys),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // A row reads high when a pressed key joins it to the driven column.
    always_comb begin
        row_keys = 4'b0;
        for (int r = 0; r < 4; r++) row_keys[r] = |(pressed[r] & col_keys);
    end

    always @(negedge clk) begin
        if (mon_en && key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: key_code=%h, required no pulse", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_code !== mon_exp) begin
                    fails++;
                    $display("FAIL pulse_code: got %h, required %h", key_code, mon_exp);
                end
            end
            checks++;
            if (key_held !== 1'b1) begin
                fails++;
                $display("FAIL held_at_pulse: got %b, required 1", key_held);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic v, input int budget, input string name);
        int i;
        i = 0;
        while (key_held !== v && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(key_held), 32'(v));
    endtask

    task automatic wait_col_start(input logic [3:0] col, input string name);
        logic [3:0] prev;
        int i;
        i = 0;
        prev = col_keys;
        @(negedge clk);
        while (!(col_keys == col && prev != col) && i < 200) begin
            prev = col_keys;
            @(negedge clk);
            i++;
        end
        check(name, 32'(col_keys), 32'(col));
    endtask

    initial begin
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0;
        rst = 1'b1;
        step(2);
        mon_en = 1'b1;

        // Test 1: reset state, idle scan 3 cycles per column.
        check("reset_col", 32'(col_keys), 32'h1);
        check("reset_code", 32'(key_code), 32'h0);
        check("reset_valid", 32'(key_valid), 32'h0);
        check("reset_held", 32'(key_held), 32'h0);
        rst = 1'b0;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            exp_col = 4'b0001 << ((i / 3) % 4);
            check("idle_scan_col", 32'(col_keys), 32'(exp_col));
        end
        check("idle_code", 32'(key_code), 32'h0);
        check("idle_held", 32'(key_held), 32'h0);

        // Test 2: row1/col2 -> 6, column held while pressed.
        pressed[1][2] = 1'b1;
        exp_q.push_back(4'h6);
        wait_held(1'b1, 100, "press_6_held");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("held_col_6", 32'(col_keys), 32'h4);
            check("held_6", 32'(key_held), 32'h1);
        end

        // Test 3: second key while held is ignored, accepted after release.
        pressed[2][3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("held_col_6_two_keys", 32'(col_keys), 32'h4);
        end
        pressed[1][2] = 1'b0;
        wait_held(1'b0, 50, "release_6");
        exp_q.push_back(4'hC);
        wait_held(1'b1, 100, "press_c_held");
        check("code_c", 32'(key_code), 32'hC);
        pressed[2][3] = 1'b0;
        wait_held(1'b0, 50, "release_c");

        // Test 4: short press that drops out during debounce.
        wait_col_start(4'b0001, "sync_col0_short");
        pressed[0][0] = 1'b1;
        step(3);
        pressed[0][0] = 1'b0;
        wait_col_start(4'b0010, "scan_resumes");
        check("short_code_kept", 32'(key_code), 32'hC);
        check("short_held", 32'(key_held), 32'h0);

        // Test 5: release bounce on row3/col1 (code 0).
        pressed[3][1] = 1'b1;
        exp_q.push_back(4'h0);
        wait_held(1'b1, 100, "press_0_held");
        step(2);
        pressed[3][1] = 1'b0;
        step(2);
        pressed[3][1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("bounce_held", 32'(key_held), 32'h1);
        end
        pressed[3][1] = 1'b0;
        wait_held(1'b0, 50, "release_0");

        // Test 6a: reset while HELD on row2/col0 (code 7).
        pressed[2][0] = 1'b1;
        exp_q.push_back(4'h7);
        wait_held(1'b1, 100, "press_7_held");
        check("code_7", 32'(key_code), 32'h7);
        step(2);
        rst = 1'b1;
        pressed[2][0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_held_col", 32'(col_keys), 32'h1);
        check("rst_held_held", 32'(key_held), 32'h0);
        check("rst_held_code", 32'(key_code), 32'h0);
        check("rst_held_valid", 32'(key_valid), 32'h0);
        step(30);

        // Test 6b: reset while debouncing row0/col0; the press must never pulse.
        wait_col_start(4'b0001, "sync_col0_rst");
        pressed[0][0] = 1'b1;
        step(4);
        rst = 1'b1;
        pressed[0][0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_deb_col", 32'(col_keys), 32'h1);
        check("rst_deb_held", 32'(key_held), 32'h0);
        check("rst_deb_code", 32'(key_code), 32'h0);
        check("rst_deb_valid", 32'(key_valid), 32'h0);
        step(30);
        check("rst_deb_held_late", 32'(key_held), 32'h0);

        check("pending_pulses", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad. It drives one column at a time, samples the rows through a synchronizer, and debounces both press and release. It emits a one-cycle valid pulse with the 4-bit hex code of each new key. It sits between the keypad pins and the two-digit display shift logic (hex_R/hex_L), replacing ad-hoc scan/debounce glue with one sequenced FSM.

Parameters:
SETTLE_CYCLES, 48, cycles a column is driven before rows are sampled; min 3 (covers 2-flop sync plus 1).
DEBOUNCE_CYCLES, 480000, consecutive stable cycles required to accept a press or a release; min 1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
row_keys  input  4  keypad rows, asynchronous, pulled down externally; 1 = driven column connected through a pressed key
col_keys  output  4  column drive, one-hot active-high
key_code  output  4  hex code of last accepted key
key_valid  output  1  one-cycle pulse when key_code updates
key_held  output  1  high while the accepted key is considered pressed

Behaviour:
- One clock domain, clk. Reset is synchronous, active-high on rst.
- Reset values:
  - col_keys=4'b0001, key_code=4'h0, key_valid=0, key_held=0.
  - state=SCAN, col_idx=0, all counters 0, sync flops 0.
- Synchronizer: row_keys passes through 2 flops to give row_s. Only row_s is used internally.
- Key map [row][col]: row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 E,0,F,D. For example, row1/col2 gives 6 and row2/col3 gives C.
- Counters are sized $clog2(max param + 1). A counter resets to 0 on every state change and on every column change.
- State SCAN:
  - col_keys = onehot(col_idx). Settle counter increments each cycle.
  - When settle == SETTLE_CYCLES-1, sample row_s.
  - If row_s == 0: advance col_idx (3 wraps to 0) and restart settle.
  - If row_s != 0: latch row_idx as the lowest set row bit, keep col_idx, go to DEBOUNCE.
- State DEBOUNCE:
  - The column is held. The counter increments each cycle while row_s[row_idx]=1.
  - If row_s[row_idx]=0 on any cycle: return to SCAN on the same column with settle restarted; no output change.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the row still high:
    - Next cycle: key_code = map[row_idx][col_idx], key_valid=1 for exactly one cycle, key_held=1.
    - The FSM goes to HELD.
- State HELD:
  - The column is held. All other rows and columns are ignored; a second key pressed concurrently never produces a pulse.
  - If row_s[row_idx]=0: go to RELEASE.
- State RELEASE:
  - The counter increments while row_s[row_idx]=0.
  - If row_s[row_idx]=1 before completion: return to HELD with no new pulse (bounce on release).
  - When the counter reaches DEBOUNCE_CYCLES-1: key_held=0, advance col_idx, go to SCAN.
  - key_code retains its value.
- key_valid is high only on the cycle after DEBOUNCE completes. It never fires twice for one physical press.
- Press latency: from a row edge on the active column to key_valid is at most 2 (sync) + SETTLE_CYCLES + DEBOUNCE_CYCLES + 1 cycles. Worst case adds 3 full column scans.
- rst asserted in any state: on the next edge, all reset values are restored, a pending pulse is dropped, and key_held is cleared.
- Multiple rows on one column: lowest row index wins; the others are ignored until return to SCAN.

Test Plan:
All tests use SETTLE_CYCLES=3, DEBOUNCE_CYCLES=4.
1. Reset, no keys for 40 cycles -> col_keys cycles 0001,0010,0100,1000,0001 with 3 cycles each; key_valid never asserts; key_code=0; key_held=0.
2. Close row1/col2 and hold -> exactly one key_valid pulse with key_code=4'h6 and key_held=1. While held, col_keys stays 0100.
3. With the key from test 2 held, also close row2/col3 -> no new pulse. Release row1/col2 for at least 4 cycles -> key_held=0 and scanning resumes. The second key is then accepted: one pulse, key_code=4'hC.
4. Close row0/col0 for only 2 cycles during DEBOUNCE, then open -> no pulse, key_code unchanged, scanning continues.
5. During HELD on row3/col1 (code 0), open for 2 cycles then reclose -> no second pulse and key_held stays 1. A final open for 4 or more cycles gives key_held=0.
6. Assert rst for 1 cycle during DEBOUNCE and during HELD -> next cycle col_keys=0001, key_held=0, key_code=0, and no pulse ever emitted for the interrupted press.
